// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between the EX stage (r0)
// and the address/branch helper (r1), with a one-entry result slot per requester.
module alu_share_arb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,

  input  logic             r0_valid_i,
  output logic             r0_ready_o,
  input  logic [WIDTH-1:0] r0_a_i,
  input  logic [WIDTH-1:0] r0_b_i,
  input  logic [2:0]       r0_gin_i,
  output logic             r0_rvalid_o,
  input  logic             r0_rready_i,
  output logic [WIDTH-1:0] r0_result_o,
  output logic [2:0]       r0_flags_o,

  input  logic             r1_valid_i,
  output logic             r1_ready_o,
  input  logic [WIDTH-1:0] r1_a_i,
  input  logic [WIDTH-1:0] r1_b_i,
  input  logic [2:0]       r1_gin_i,
  output logic             r1_rvalid_o,
  input  logic             r1_rready_i,
  output logic [WIDTH-1:0] r1_result_o,
  output logic [2:0]       r1_flags_o,

  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_gin_o,
  input  logic [WIDTH-1:0] alu_sum_i,
  input  logic             alu_zout_i,
  input  logic             alu_nout_i,
  input  logic             alu_ovf_i
);

  logic [1:0]       valid, rready, elig, grant;
  logic [1:0]       rvalid_d, rvalid_q;
  logic             last_grant_d, last_grant_q;
  logic [WIDTH-1:0] result_q [2];
  logic [2:0]       flags_q  [2];
  logic [WIDTH-1:0] cap_result;
  logic [2:0]       cap_flags;
  logic             illegal_op, arith_op;

  assign valid  = {r1_valid_i, r0_valid_i};
  assign rready = {r1_rready_i, r0_rready_i};
  // A slot being drained this cycle can be refilled in the same cycle.
  assign elig   = valid & (~rvalid_q | rready);

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_gin_o = 3'b000;
    unique case (grant)
      2'b01: begin
        alu_a_o   = r0_a_i;
        alu_b_o   = r0_b_i;
        alu_gin_o = r0_gin_i;
      end
      2'b10: begin
        alu_a_o   = r1_a_i;
        alu_b_o   = r1_b_i;
        alu_gin_o = r1_gin_i;
      end
      default: ;
    endcase
  end

  assign illegal_op = (alu_gin_o[2:1] == 2'b10);
  // The ALU overflow output is only meaningful for add and sub.
  assign arith_op   = (alu_gin_o == 3'b010) || (alu_gin_o == 3'b110);

  always_comb begin
    if (illegal_op) begin
      cap_result = '0;
      cap_flags  = 3'b001;
    end else begin
      cap_result = alu_sum_i;
      cap_flags  = {arith_op & alu_ovf_i, alu_nout_i, alu_zout_i};
    end
  end

  always_comb begin
    rvalid_d     = rvalid_q;
    last_grant_d = last_grant_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        rvalid_d[i] = 1'b1;
      end else if (rready[i]) begin
        rvalid_d[i] = 1'b0;
      end
    end
    if (|grant) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rvalid_q     <= '0;
      last_grant_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        flags_q[i]  <= '0;
      end
    end else begin
      rvalid_q     <= rvalid_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          result_q[i] <= cap_result;
          flags_q[i]  <= cap_flags;
        end
      end
    end
  end

  assign r0_ready_o  = grant[0];
  assign r1_ready_o  = grant[1];
  assign r0_rvalid_o = rvalid_q[0];
  assign r1_rvalid_o = rvalid_q[1];
  assign r0_result_o = result_q[0];
  assign r1_result_o = result_q[1];
  assign r0_flags_o  = flags_q[0];
  assign r1_flags_o  = flags_q[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU, directed vector table, per-requester
// scoreboards fed on acceptance and drained on result consumption.
module tb_alu_share_arb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        r0_valid_i, r0_ready_o, r0_rvalid_o, r0_rready_i;
  logic [31:0] r0_a_i, r0_b_i, r0_result_o;
  logic [2:0]  r0_gin_i, r0_flags_o;
  logic        r1_valid_i, r1_ready_o, r1_rvalid_o, r1_rready_i;
  logic [31:0] r1_a_i, r1_b_i, r1_result_o;
  logic [2:0]  r1_gin_i, r1_flags_o;
  logic [31:0] alu_a_o, alu_b_o, alu_sum_i;
  logic [2:0]  alu_gin_o;
  logic        alu_zout_i, alu_nout_i, alu_ovf_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  gin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [2:0]  exp_flg;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];

  alu_share_arb #(.WIDTH(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_a_i(r0_a_i), .r0_b_i(r0_b_i),
    .r0_gin_i(r0_gin_i), .r0_rvalid_o(r0_rvalid_o), .r0_rready_i(r0_rready_i),
    .r0_result_o(r0_result_o), .r0_flags_o(r0_flags_o),
    .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_a_i(r1_a_i), .r1_b_i(r1_b_i),
    .r1_gin_i(r1_gin_i), .r1_rvalid_o(r1_rvalid_o), .r1_rready_i(r1_rready_i),
    .r1_result_o(r1_result_o), .r1_flags_o(r1_flags_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_gin_o(alu_gin_o), .alu_sum_i(alu_sum_i),
    .alu_zout_i(alu_zout_i), .alu_nout_i(alu_nout_i), .alu_ovf_i(alu_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural ALU; overflow is deliberately stale (1) for non-arithmetic codes.
  always_comb begin
    alu_ovf_i = 1'b1;
    case (alu_gin_o)
      3'b010: begin
        alu_sum_i = alu_a_o + alu_b_o;
        alu_ovf_i = (alu_a_o[31] == alu_b_o[31]) && (alu_sum_i[31] != alu_a_o[31]);
      end
      3'b110: begin
        alu_sum_i = alu_a_o - alu_b_o;
        alu_ovf_i = (alu_a_o[31] != alu_b_o[31]) && (alu_sum_i[31] != alu_a_o[31]);
      end
      3'b111:  alu_sum_i = ($signed(alu_a_o) < $signed(alu_b_o)) ? 32'd1 : 32'd0;
      3'b000:  alu_sum_i = alu_a_o & alu_b_o;
      3'b001:  alu_sum_i = alu_a_o | alu_b_o;
      3'b011:  alu_sum_i = alu_a_o >> alu_b_o[4:0];
      default: alu_sum_i = alu_a_o ^ alu_b_o ^ 32'hDEAD_BEEF;
    endcase
    alu_zout_i = (alu_sum_i == 32'd0);
    alu_nout_i = alu_sum_i[31];
  end

  function automatic exp_t model(input logic [2:0] g, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (g)
      3'b010: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b110: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b011: r = a >> b[4:0];
      default: return '{res: 32'd0, flg: 3'b001};
    endcase
    return '{res: r, flg: {v, r[31], r == 32'd0}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on acceptance, pop when the slot is consumed.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_i) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0_rvalid_o && r0_rready_i) begin
        if (q0.size() == 0) chk("sb0_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("sb0_result", r0_result_o, e.res);
          chk("sb0_flags", {29'd0, r0_flags_o}, {29'd0, e.flg});
        end
      end
      if (r1_rvalid_o && r1_rready_i) begin
        if (q1.size() == 0) chk("sb1_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("sb1_result", r1_result_o, e.res);
          chk("sb1_flags", {29'd0, r1_flags_o}, {29'd0, e.flg});
        end
      end
      if (r0_valid_i && r0_ready_o) q0.push_back(model(r0_gin_i, r0_a_i, r0_b_i));
      if (r1_valid_i && r1_ready_o) q1.push_back(model(r1_gin_i, r1_a_i, r1_b_i));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t vecs[11];
    int   g;
    vecs[0]  = '{"add_5_7",     3'b010, 32'd5,          32'd7,  32'd12,         3'b000};
    vecs[1]  = '{"sub_3_3",     3'b110, 32'd3,          32'd3,  32'd0,          3'b001};
    vecs[2]  = '{"add_ovf",     3'b010, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  3'b110};
    vecs[3]  = '{"or_masked",   3'b001, 32'h8000_0000,  32'd0,  32'h8000_0000,  3'b010};
    vecs[4]  = '{"slt_2_9",     3'b111, 32'd2,          32'd9,  32'd1,          3'b000};
    vecs[5]  = '{"and",         3'b000, 32'h0000_F0F0,  32'h0FF0, 32'h0000_00F0, 3'b000};
    vecs[6]  = '{"srl",         3'b011, 32'h8000_0000,  32'd4,  32'h0800_0000,  3'b000};
    vecs[7]  = '{"illegal_101", 3'b101, 32'd1,          32'd1,  32'd0,          3'b001};
    vecs[8]  = '{"illegal_100", 3'b100, 32'd6,          32'd3,  32'd0,          3'b001};
    vecs[9]  = '{"sub_neg",     3'b110, 32'd1,          32'd2,  32'hFFFF_FFFF,  3'b010};
    vecs[10] = '{"sub_ovf",     3'b110, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  3'b100};

    reset_i = 1'b1;
    {r0_valid_i, r0_rready_i, r1_valid_i, r1_rready_i} = '0;
    {r0_a_i, r0_b_i, r1_a_i, r1_b_i} = '0;
    r0_gin_i = 3'b000;
    r1_gin_i = 3'b000;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    r0_rready_i = 1'b1;
    r1_rready_i = 1'b1;

    @(negedge clk_i);
    chk("rst_r0_rvalid", r0_rvalid_o, 1'b0);
    chk("rst_r1_rvalid", r1_rvalid_o, 1'b0);
    chk("rst_r0_result", r0_result_o, 32'd0);
    chk("rst_r1_result", r1_result_o, 32'd0);
    chk("rst_flags", {26'd0, r0_flags_o, r1_flags_o}, 32'd0);
    chk("idle_alu_drive", {29'd0, alu_gin_o} | alu_a_o | alu_b_o, 32'd0);

    // Single-op table on requester 0: same-cycle ready, 1-cycle result, hold after consume.
    foreach (vecs[i]) begin
      step();
      r0_valid_i = 1'b1;
      r0_a_i = vecs[i].a;
      r0_b_i = vecs[i].b;
      r0_gin_i = vecs[i].gin;
      @(negedge clk_i);
      chk({vecs[i].name, "_ready"}, {r1_ready_o, r0_ready_o}, 2'b01);
      chk({vecs[i].name, "_alu_a"}, alu_a_o, vecs[i].a);
      chk({vecs[i].name, "_alu_b"}, alu_b_o, vecs[i].b);
      chk({vecs[i].name, "_alu_gin"}, {29'd0, alu_gin_o}, {29'd0, vecs[i].gin});
      step();
      r0_valid_i = 1'b0;
      @(negedge clk_i);
      chk({vecs[i].name, "_rvalid"}, r0_rvalid_o, 1'b1);
      chk({vecs[i].name, "_result"}, r0_result_o, vecs[i].exp_res);
      chk({vecs[i].name, "_flags"}, {29'd0, r0_flags_o}, {29'd0, vecs[i].exp_flg});
      step();
      @(negedge clk_i);
      chk({vecs[i].name, "_drained"}, r0_rvalid_o, 1'b0);
      chk({vecs[i].name, "_held"}, r0_result_o, vecs[i].exp_res);
    end

    // Contention after reset: grants alternate starting with requester 0.
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    r0_valid_i = 1'b1; r0_gin_i = 3'b110; r0_a_i = 32'd3; r0_b_i = 32'd3;
    r1_valid_i = 1'b1; r1_gin_i = 3'b111; r1_a_i = 32'd2; r1_b_i = 32'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      g = r0_ready_o ? 0 : (r1_ready_o ? 1 : 2);
      chk("contention_grant", g, k % 2);
      chk("contention_onehot", {31'd0, r0_ready_o & r1_ready_o}, 32'd0);
      step();
    end
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    repeat (2) step();

    // Backpressure on requester 1 while requester 0 keeps being served.
    r1_valid_i = 1'b1; r1_gin_i = 3'b010; r1_a_i = 32'd10; r1_b_i = 32'd20;
    r1_rready_i = 1'b0;
    @(negedge clk_i);
    chk("bp_first_grant", r1_ready_o, 1'b1);
    step();
    r1_gin_i = 3'b110; r1_a_i = 32'd100; r1_b_i = 32'd1;
    r0_valid_i = 1'b1; r0_gin_i = 3'b000; r0_a_i = 32'hFF; r0_b_i = 32'h0F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("bp_r1_blocked", r1_ready_o, 1'b0);
      chk("bp_r0_served", r0_ready_o, 1'b1);
      chk("bp_r1_rvalid", r1_rvalid_o, 1'b1);
      chk("bp_r1_result", r1_result_o, 32'd30);
      step();
    end
    r1_rready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release", {r1_ready_o, r0_ready_o}, 2'b10);
    step();
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    @(negedge clk_i);
    chk("bp_new_result", r1_result_o, 32'd99);

    // Requester 1 alone sustains one op per cycle.
    for (int k = 0; k < 4; k++) begin
      step();
      r1_valid_i = 1'b1; r1_gin_i = 3'b010; r1_a_i = k; r1_b_i = 32'd1000;
      @(negedge clk_i);
      chk("sustain_ready", r1_ready_o, 1'b1);
    end
    step();
    r1_valid_i = 1'b0;

    // Reset mid-operation discards pending and in-flight results.
    r0_rready_i = 1'b0;
    r0_valid_i = 1'b1; r0_gin_i = 3'b010; r0_a_i = 32'd1; r0_b_i = 32'd2;
    @(negedge clk_i);
    chk("mid_r0_ready", r0_ready_o, 1'b1);
    step();
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b1; r1_gin_i = 3'b010; r1_a_i = 32'd4; r1_b_i = 32'd5;
    r1_rready_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("mid_r0_pending", r0_rvalid_o, 1'b1);
    chk("mid_r1_granted", r1_ready_o, 1'b1);
    step();
    reset_i = 1'b0;
    r1_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rvalids", {r1_rvalid_o, r0_rvalid_o}, 2'b00);
    chk("mid_results", r0_result_o | r1_result_o, 32'd0);
    chk("mid_flags", {26'd0, r0_flags_o, r1_flags_o}, 32'd0);
    step();
    r0_rready_i = 1'b1; r1_rready_i = 1'b1;
    r0_valid_i = 1'b1; r0_gin_i = 3'b001; r0_a_i = 32'h10; r0_b_i = 32'h01;
    r1_valid_i = 1'b1; r1_gin_i = 3'b000; r1_a_i = 32'h33; r1_b_i = 32'h0F;
    @(negedge clk_i);
    chk("post_rst_first", {r1_ready_o, r0_ready_o}, 2'b01);
    step();
    @(negedge clk_i);
    chk("post_rst_second", {r1_ready_o, r0_ready_o}, 2'b10);
    step();
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    repeat (3) step();

    chk("sb0_drained", q0.size(), 32'd0);
    chk("sb1_drained", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
